// File: rtl/uart_rx.sv
// 8N1 UART receiver with a two-flop input synchronizer and mid-bit sampling.
// The received byte is held for the bus, with sticky overrun and a one-cycle framing-error pulse.
`timescale 1ns/1ps
module uart_rx #(
   parameter int BUS_CLK = 10_000_000,
   parameter int BAUD    = 9600
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clk_en,
   input  logic       rx,
   output logic [7:0] din,
   output logic       rdy,
   input  logic       rd,
   output logic       overrun,
   output logic       frame_err,
   output logic       busy
);

   localparam int CPB  = BUS_CLK / BAUD;
   localparam int HALF = CPB / 2;
   localparam int CW   = $clog2(CPB);
   localparam logic [CW-1:0] CNT_LAST  = CW'(CPB - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      START   = 3'd1,
      DATA    = 3'd2,
      STOP    = 3'd3,
      WAIT_HI = 3'd4
   } state_t;

   state_t          state_r, state_next_s;
   logic            sync1_r, rx_s;
   logic [CW-1:0]   cnt_r, cnt_next_s;
   logic [2:0]      idx_r, idx_next_s;
   logic [7:0]      shreg_r, shreg_next_s;
   logic            good_s, ferr_s;

   // Two-flop synchronizer for the asynchronous serial line
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_r <= 1'b1;
         rx_s    <= 1'b1;
      end else if (clk_en) begin
         sync1_r <= rx;
         rx_s    <= sync1_r;
      end
   end

   // Next-state, bit counter, bit index and shift register logic
   always_comb begin
      state_next_s = state_r;
      cnt_next_s   = cnt_r;
      idx_next_s   = idx_r;
      shreg_next_s = shreg_r;
      good_s       = 1'b0;
      ferr_s       = 1'b0;
      case (state_r)
         IDLE: begin
            cnt_next_s = '0;
            if (!rx_s) state_next_s = START;
            else       state_next_s = IDLE;
         end
         START: begin
            if (cnt_r == HALF_LAST) begin
               cnt_next_s = '0;
               idx_next_s = 3'd0;
               // a start bit that is gone by mid-bit was a glitch
               if (!rx_s) state_next_s = DATA;
               else       state_next_s = IDLE;
            end else begin
               cnt_next_s = cnt_r + CW'(1);
            end
         end
         DATA: begin
            if (cnt_r == CNT_LAST) begin
               shreg_next_s[idx_r] = rx_s;
               cnt_next_s          = '0;
               idx_next_s          = idx_r + 3'd1;
               if (idx_r == 3'd7) state_next_s = STOP;
               else               state_next_s = DATA;
            end else begin
               cnt_next_s = cnt_r + CW'(1);
            end
         end
         STOP: begin
            if (cnt_r == CNT_LAST) begin
               cnt_next_s = '0;
               if (rx_s) begin
                  good_s       = 1'b1;
                  state_next_s = IDLE;
               end else begin
                  ferr_s       = 1'b1;
                  state_next_s = WAIT_HI;
               end
            end else begin
               cnt_next_s = cnt_r + CW'(1);
            end
         end
         WAIT_HI: begin
            cnt_next_s = '0;
            if (rx_s) state_next_s = IDLE;
            else      state_next_s = WAIT_HI;
         end
         default: begin
            state_next_s = IDLE;
            cnt_next_s   = '0;
         end
      endcase
   end

   // Receive-path state registers, advanced only on enabled cycles
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
         cnt_r   <= '0;
         idx_r   <= 3'd0;
         shreg_r <= 8'h00;
         busy    <= 1'b0;
      end else if (clk_en) begin
         state_r <= state_next_s;
         cnt_r   <= cnt_next_s;
         idx_r   <= idx_next_s;
         shreg_r <= shreg_next_s;
         busy    <= (state_next_s != IDLE);
      end
   end

   // Bus-side holding register; rd is honoured every cycle, a new byte beats a same-cycle rd
   always_ff @(posedge clk) begin
      if (rst) begin
         din       <= 8'h00;
         rdy       <= 1'b0;
         overrun   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         frame_err <= clk_en & ferr_s;
         if (clk_en && good_s) begin
            din <= shreg_r;
            rdy <= 1'b1;
            if (rdy && !rd) overrun <= 1'b1;
         end else if (rd) begin
            rdy     <= 1'b0;
            overrun <= 1'b0;
         end
      end
   end

endmodule
